mips_multicycle_cpu: RTL

Multicycle MIPS-subset core: the next-generation replacement for the single-cycle datapath. Each instruction runs over 3–5 states of one FSM through a single unified instruction/data memory port with a valid/ready handshake, so memory may insert wait states. Address width and reset vector are parameters. The block adds branch, jump and halt support, and exposes a retire strobe for the bench.

---
 rtl/mips_multicycle_cpu.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/mips_multicycle_cpu.sv
// Multicycle MIPS-subset core: one FSM sequencing fetch/decode/exec/mem/wb over a
// single shared memory port with valid/ready handshake; branch, jump and halt.
//
// state    | meaning
// ---------+--------------------------------------------------------
// S_RST    | idle cycle after reset, no memory request
// S_FETCH  | request word at PC; on ready latch IR and advance PC
// S_DECODE | read rs/rt into A/B, precompute branch target in ALUOut
// S_EXEC   | ALU op, address calc, branch/jump resolve, or trap
// S_MEM    | load/store at ALUOut, held until ready
// S_WB     | write ALUOut or MDR to destination register
// S_HALT   | stopped until reset
module mips_multicycle_cpu #(
   parameter int                ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              reset,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata,
   input  logic              mem_ready,
   output logic              halted,
   output logic              retire,
   output logic [ADDR_W-1:0] dbg_pc
);

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_HALT  = 6'h3F;

   localparam logic [5:0] FN_SLL = 6'h00;
   localparam logic [5:0] FN_SRL = 6'h02;
   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_SLT = 6'h2A;

   typedef enum logic [2:0] {
      S_RST, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
   } state_t;

   state_t state, state_nxt;

   logic [ADDR_W-1:0] pc;
   logic [31:0]       ir, reg_a, reg_b, alu_out, mdr;
   logic [31:0]       rf [32];

   logic [5:0]  opcode, funct;
   logic [4:0]  rs, rt, rd, shamt;
   logic [15:0] imm;
   logic [31:0] imm_sext, imm_zext, br_off, pc_ext, j_full;
   logic [ADDR_W-1:0] br_target, j_target;
   logic [4:0]  wb_dst;
   logic [31:0] wb_data;
   logic [31:0] alu_res;
   logic        op_legal, branch_taken, is_sw;

   assign opcode = ir[31:26];
   assign rs     = ir[25:21];
   assign rt     = ir[20:16];
   assign rd     = ir[15:11];
   assign shamt  = ir[10:6];
   assign funct  = ir[5:0];
   assign imm    = ir[15:0];

   assign imm_sext  = {{16{imm[15]}}, imm};
   assign imm_zext  = {16'h0000, imm};
   assign br_off    = {imm_sext[29:0], 2'b00};
   assign br_target = pc + br_off[ADDR_W-1:0];

   // jump keeps the top nibble of the already-incremented PC
   assign pc_ext   = 32'(pc);
   assign j_full   = (pc_ext & 32'hF000_0000) | {4'h0, ir[25:0], 2'b00};
   assign j_target = j_full[ADDR_W-1:0];

   assign wb_dst  = (opcode == OP_RTYPE) ? rd : rt;
   assign wb_data = (opcode == OP_LW) ? mdr : alu_out;
   assign is_sw   = (opcode == OP_SW);

   assign branch_taken = ((opcode == OP_BEQ) && (reg_a == reg_b)) ||
                         ((opcode == OP_BNE) && (reg_a != reg_b));

   always_comb begin
      alu_res  = '0;
      op_legal = 1'b1;
      case (opcode)
         OP_RTYPE: begin
            case (funct)
               FN_ADD:  alu_res = reg_a + reg_b;
               FN_SUB:  alu_res = reg_a - reg_b;
               FN_AND:  alu_res = reg_a & reg_b;
               FN_OR:   alu_res = reg_a | reg_b;
               FN_SLT:  alu_res = {31'h0, $signed(reg_a) < $signed(reg_b)};
               FN_SLL:  alu_res = reg_b << shamt;
               FN_SRL:  alu_res = reg_b >> shamt;
               default: op_legal = 1'b0;
            endcase
         end
         OP_ADDI:             alu_res = reg_a + imm_sext;
         OP_ANDI:             alu_res = reg_a & imm_zext;
         OP_ORI:              alu_res = reg_a | imm_zext;
         OP_LW, OP_SW:        alu_res = reg_a + imm_sext;
         OP_BEQ, OP_BNE, OP_J: alu_res = '0;
         OP_HALT:             op_legal = 1'b0;
         default:             op_legal = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) state <= S_RST;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      retire    = 1'b0;
      case (state)
         S_RST:    state_nxt = S_FETCH;
         S_FETCH: begin
            mem_req  = 1'b1;
            mem_addr = {pc[ADDR_W-1:2], 2'b00};
            if (mem_ready) state_nxt = S_DECODE;
         end
         S_DECODE: state_nxt = S_EXEC;
         S_EXEC: begin
            if (!op_legal) begin
               state_nxt = S_HALT;
            end else begin
               case (opcode)
                  OP_LW, OP_SW: state_nxt = S_MEM;
                  OP_BEQ, OP_BNE, OP_J: begin
                     retire    = 1'b1;
                     state_nxt = S_FETCH;
                  end
                  default: state_nxt = S_WB;
               endcase
            end
         end
         S_MEM: begin
            mem_req   = 1'b1;
            mem_we    = is_sw;
            mem_addr  = {alu_out[ADDR_W-1:2], 2'b00};
            mem_wdata = is_sw ? reg_b : '0;
            if (mem_ready) begin
               if (is_sw) begin
                  retire    = 1'b1;
                  state_nxt = S_FETCH;
               end else begin
                  state_nxt = S_WB;
               end
            end
         end
         S_WB: begin
            retire    = 1'b1;
            state_nxt = S_FETCH;
         end
         S_HALT:  state_nxt = S_HALT;
         default: state_nxt = S_RST;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc      <= RESET_PC;
         ir      <= '0;
         reg_a   <= '0;
         reg_b   <= '0;
         alu_out <= '0;
         mdr     <= '0;
         for (int i = 0; i < 32; i++) rf[i] <= '0;
      end else begin
         case (state)
            S_FETCH: begin
               if (mem_ready) begin
                  ir <= mem_rdata;
                  pc <= pc + ADDR_W'(4);
               end
            end
            S_DECODE: begin
               reg_a   <= rf[rs];
               reg_b   <= rf[rt];
               alu_out <= 32'(br_target);
            end
            S_EXEC: begin
               if (opcode == OP_J)   pc <= j_target;
               else if (branch_taken) pc <= alu_out[ADDR_W-1:0];
               else                   alu_out <= alu_res;
            end
            S_MEM: begin
               if (mem_ready && !is_sw) mdr <= mem_rdata;
            end
            S_WB: begin
               if (wb_dst != 5'd0) rf[wb_dst] <= wb_data;
            end
            default: ;
         endcase
      end
   end

   assign halted = (state == S_HALT);
   assign dbg_pc = pc;

endmodule
